// File: rtl/uriscv_irq_ctrl.sv
// Interrupt controller for the UriSCV core: synchronised edge/level sources, fixed lowest-id
// priority, a claim/complete handshake and a registered request/vector pair for the core.
module uriscv_irq_ctrl #(
  parameter int unsigned NUM_SRC = 8,
  parameter logic [31:0] VEC_RST = 32'h0000_0100
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [4:0]         addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  output logic               intr_o,
  output logic [31:0]        isr_vector_o
);

  localparam logic [2:0] RegPending = 3'd0;
  localparam logic [2:0] RegEnable  = 3'd1;
  localparam logic [2:0] RegEdge    = 3'd2;
  localparam logic [2:0] RegClaim   = 3'd3;
  localparam logic [2:0] RegVbase   = 3'd4;

  typedef enum logic [1:0] {StIdle, StPend, StService} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d, enable_q, edge_q;
  logic [NUM_SRC-1:0] edge_set, sw_clr, claim_clr;
  logic [31:0]        vbase_q, vec_q, rdata_q, rdata_d;
  logic [4:0]         claimed_q, claimed_d, active_id;
  logic               ack_q, intr_q;
  logic [2:0]         reg_sel;
  logic               rd_req, wr_req, claim_rd, complete_wr;
  logic               unused_addr;

  assign reg_sel     = addr_i[4:2];
  assign unused_addr = ^addr_i[1:0];
  assign rd_req      = req_i & ~we_i;
  assign wr_req      = req_i & we_i;
  assign claim_rd    = rd_req && (reg_sel == RegClaim) && (state_q == StPend) &&
                       (active_id != 5'd0);
  assign complete_wr = wr_req && (reg_sel == RegClaim) && (wdata_i[4:0] == claimed_q);

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    active_id = 5'd0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pend_q[i] && enable_q[i]) active_id = 5'(i + 1);
    end
  end

  always_comb begin
    claim_clr = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      claim_clr[i] = claim_rd && (active_id == 5'(i + 1));
    end
  end

  assign edge_set = sync2_q & ~prev_q;
  assign sw_clr   = (wr_req && (reg_sel == RegPending)) ? wdata_i[NUM_SRC-1:0] : '0;
  // Set beats clear for edge bits; level bits simply track the synchronised input.
  assign pend_d   = (edge_q & ((pend_q & ~(sw_clr | claim_clr)) | edge_set)) |
                    (~edge_q & sync2_q);

  always_comb begin
    state_d   = state_q;
    claimed_d = claimed_q;
    case (state_q)
      StIdle: begin
        if (active_id != 5'd0) state_d = StPend;
      end
      StPend: begin
        if (active_id == 5'd0) begin
          state_d = StIdle;
        end else if (claim_rd) begin
          state_d   = StService;
          claimed_d = active_id;
        end
      end
      StService: begin
        if (complete_wr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (rd_req) begin
      case (reg_sel)
        RegPending: rdata_d[NUM_SRC-1:0] = pend_q;
        RegEnable:  rdata_d[NUM_SRC-1:0] = enable_q;
        RegEdge:    rdata_d[NUM_SRC-1:0] = edge_q;
        RegClaim:   rdata_d[4:0]         = claim_rd ? active_id : 5'd0;
        RegVbase:   rdata_d              = vbase_q;
        default:    rdata_d              = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      vbase_q   <= VEC_RST;
      vec_q     <= VEC_RST;
      claimed_q <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= irq_src_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pend_q    <= pend_d;
      claimed_q <= claimed_d;
      rdata_q   <= rdata_d;
      ack_q     <= req_i;
      intr_q    <= (state_d == StPend);
      // Vector is frozen while a handler runs so the core sees a stable address.
      if (state_q != StService) vec_q <= vbase_q + {25'b0, active_id, 2'b00};
      if (wr_req) begin
        case (reg_sel)
          RegEnable: enable_q <= wdata_i[NUM_SRC-1:0];
          RegEdge:   edge_q   <= wdata_i[NUM_SRC-1:0];
          RegVbase:  vbase_q  <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  assign rdata_o      = rdata_q;
  assign ack_o        = ack_q;
  assign intr_o       = intr_q;
  assign isr_vector_o = vec_q;

endmodule

// File: doc/uriscv_irq_ctrl.md
UriSCV_IRQ_CTRL -- requirements
Module: uriscv_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, 8, number of interrupt sources (1..31).
REQ-002 SHALL have parameter VEC_RST, 32'h0000_0100, reset value of VBASE.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port irq_src_i  input  NUM_SRC  asynchronous interrupt sources, bit n = source id n+1.
REQ-006 SHALL have port req_i  input  1  register access request, one access per cycle.
REQ-007 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr_i  input  5  byte offset; bits [1:0] ignored.
REQ-009 SHALL have port wdata_i  input  32  write data.
REQ-010 SHALL have port rdata_o  output  32  read data, valid with ack_o, 0 otherwise.
REQ-011 SHALL have port ack_o  output  1  one-cycle response pulse.
REQ-012 SHALL have port intr_o  output  1  registered interrupt request to the core's intr_i.
REQ-013 SHALL have port isr_vector_o  output  32  registered handler address to the core's isr_vector_i.

Function
REQ-014 SHALL use a 2-flop synchronizer per source, plus a third flop (prev) for edge detection.
REQ-015 SHALL implement registers: 0x00 PENDING, 0x04 ENABLE (RW), 0x08 EDGE (RW, 1 = rising-edge, 0 = level), 0x0C CLAIM, 0x10 VBASE (RW); other offsets read 0, writes ignored.
REQ-016 SHALL give ack_o on the cycle after req_i, with rdata_o; every request is acked, including unmapped ones.
REQ-017 SHALL set an edge pending bit on sync2 & ~prev.
REQ-018 SHALL clear an edge pending bit by PENDING write-1 or by claim.
REQ-019 SHALL give set priority when an edge pending bit has a set and a clear in the same cycle.
REQ-020 SHALL load a level pending bit from sync2 every cycle; it SHALL not be clearable by software.
REQ-021 SHALL read PENDING[NUM_SRC-1:0] as pending bits, upper bits 0.
REQ-022 SHALL define the active id as 1 + the lowest index with pending & enable set, or 0 if none.
REQ-023 SHALL have FSM states IDLE, PEND, SERVICE.
REQ-024 SHALL go IDLE->PEND when active id != 0.
REQ-025 SHALL go PEND->IDLE when active id becomes 0, e.g. enable cleared.
REQ-026 SHALL go PEND->SERVICE on a CLAIM read.
REQ-027 SHALL go SERVICE->IDLE on a CLAIM write whose wdata_i[4:0] equals the claimed id; a mismatched id SHALL be ignored.
REQ-028 SHALL, on a CLAIM read in PEND: return the active id, latch it as claimed id, and clear its pending bit if edge-mode.
REQ-029 SHALL return 0 for a CLAIM read in IDLE or SERVICE, with no state change.
REQ-030 SHALL register intr_o = 1 exactly when the next state is PEND (non-nested: no request while SERVICE).
REQ-031 SHALL register isr_vector_o each cycle as VBASE + (active id << 2) in IDLE/PEND, and hold it in SERVICE.
REQ-032 SHALL assert intr_o after the 4th rising edge when a source rises before edge 1: edges 1-2 sync, edge 3 pending, edge 4 intr_o.
REQ-033 SHALL drop intr_o on the edge that completes the ack of the claiming read.
REQ-034 SHALL wrap VBASE + offset modulo 2^32.

Reset
REQ-035 SHALL, while rst_i is high, immediately clear synchronizers, prev, PENDING, ENABLE, EDGE, claimed id, state (to IDLE), intr_o, ack_o and rdata_o, and load VBASE to VEC_RST; isr_vector_o SHALL read VEC_RST.
REQ-036 SHALL, on reset mid-SERVICE, abandon the claim; no completion is needed after reset.

Verification
REQ-037 SHALL cover edge path: ENABLE=0x01, EDGE=0x01, pulse irq_src_i[0] -> intr_o=1 at 4th edge, isr_vector_o=0x104; CLAIM read returns 1, intr_o=0 next cycle, PENDING=0.
REQ-038 SHALL cover priority: sources 2 and 5 pending and enabled -> CLAIM returns 3; complete with 3 -> next claim returns 6.
REQ-039 SHALL cover wrong completion: in SERVICE with id 1, write CLAIM=2 -> stays SERVICE; CLAIM read returns 0; write 1 -> IDLE.
REQ-040 SHALL cover level source: irq_src_i[3] held high, EDGE=0 -> PENDING W1C has no effect; after claim+complete with source still high -> intr_o reasserts next cycle.
REQ-041 SHALL cover disable while pending: clear ENABLE in PEND -> intr_o=0 one cycle after the write.
REQ-042 SHALL cover async reset mid-SERVICE: assert rst_i -> all outputs 0 without a clock edge, isr_vector_o=VEC_RST, VBASE reads 0x100.
